// File: rtl/lowpass_scheduler.sv
// Time-multiplexed RC low-pass filter: one accumulator datapath serves CHANNELS streams.
// Optional build macro LOWPASS_SCHEDULER_OVERRUN_CNT_EN adds the 8-bit overrun_cnt output.
module lowpass_scheduler #(
  parameter int CHANNELS    = 4,
  parameter int BITS_IN     = 12,
  parameter int BITS_OUT    = 16,
  parameter int ATTENUATION = 0,
  parameter int DIV_BITS    = 16
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [DIV_BITS-1:0]                 div,
  input  logic                                clear,
  input  logic [CHANNELS*BITS_IN-1:0]         in_data,
  input  logic [CHANNELS-1:0]                 in_valid,
  output logic                                out_valid,
  output logic [$clog2(CHANNELS)-1:0]         out_chan,
  output logic signed [BITS_OUT-1:0]          out_data,
  output logic                                busy,
  output logic                                overrun,
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
  output logic [7:0]                          overrun_cnt,
`endif
  output logic                                dbg_state
);

  localparam int CW = $clog2(CHANNELS);
  localparam int S  = BITS_OUT - BITS_IN;

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               ch_q, ch_d;
  logic [DIV_BITS-1:0]         cnt_q, cnt_d, div_cur_q, div_cur_d, div_eff;
  logic                        tick;
  logic signed [BITS_IN-1:0]   hold_q [CHANNELS];
  logic signed [BITS_IN-1:0]   hold_d [CHANNELS];
  logic signed [BITS_OUT-1:0]  sum_q  [CHANNELS];
  logic signed [BITS_OUT-1:0]  sum_d  [CHANNELS];
  logic                        out_valid_q, out_valid_d;
  logic [CW-1:0]               out_chan_q, out_chan_d;
  logic signed [BITS_OUT-1:0]  out_data_q, out_data_d;
  logic signed [BITS_OUT-1:0]  hold_ext, sum_sel, sum_new;
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
  logic [7:0]                  ovc_q, ovc_d;
`else
  logic                        overrun_q, overrun_d;
`endif

  // A halted divider behaves as if it just wrapped, so a new non-zero div starts counting at once.
  always_comb begin
    div_eff   = (div_cur_q == '0) ? div : div_cur_q;
    tick      = 1'b0;
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    if (div_eff == '0) begin
      cnt_d     = '0;
      div_cur_d = '0;
    end else if (cnt_q == div_eff - DIV_BITS'(1)) begin
      tick      = 1'b1;
      cnt_d     = '0;
      div_cur_d = div;
    end else begin
      cnt_d     = cnt_q + DIV_BITS'(1);
      div_cur_d = div_eff;
    end
  end

  always_comb begin
    hold_ext = {{S{hold_q[ch_q][BITS_IN-1]}}, hold_q[ch_q]};
    sum_sel  = sum_q[ch_q];
    sum_new  = sum_sel + (hold_ext >>> ATTENUATION) - (sum_sel >>> S);
  end

  // out_valid is a one-clock strobe with no backpressure: downstream must take every result.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    out_valid_d = 1'b0;
    out_chan_d  = out_chan_q;
    out_data_d  = out_data_q;
    hold_d      = hold_q;
    sum_d       = sum_q;
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
    ovc_d       = ovc_q;
`else
    overrun_d   = overrun_q;
`endif
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_valid[k]) hold_d[k] = in_data[k*BITS_IN +: BITS_IN];
    end
    if (clear) begin
      for (int k = 0; k < CHANNELS; k++) sum_d[k] = '0;
      state_d = ST_IDLE;
      ch_d    = '0;
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
      ovc_d   = 8'd0;
`else
      overrun_d = 1'b0;
`endif
    end else if (state_q == ST_IDLE) begin
      if (tick) begin
        state_d = ST_SCAN;
        ch_d    = '0;
      end
    end else begin
      sum_d[ch_q] = sum_new;
      out_valid_d = 1'b1;
      out_chan_d  = ch_q;
      out_data_d  = sum_new;
      if (ch_q == CW'(CHANNELS - 1)) begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end else begin
        ch_d = ch_q + CW'(1);
      end
      if (tick) begin
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
        ovc_d = (ovc_q == 8'hFF) ? ovc_q : ovc_q + 8'd1;
`else
        overrun_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      div_cur_q   <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        hold_q[k] <= '0;
        sum_q[k]  <= '0;
      end
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
      ovc_q       <= 8'd0;
`else
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      div_cur_q   <= div_cur_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_data_q  <= out_data_d;
      hold_q      <= hold_d;
      sum_q       <= sum_d;
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
      ovc_q       <= ovc_d;
`else
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ST_SCAN);
  assign dbg_state = (state_q == ST_SCAN);
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
  assign overrun     = (ovc_q != 8'd0);
  assign overrun_cnt = ovc_q;
`else
  assign overrun     = overrun_q;
`endif

endmodule

// File: tb/tb_lowpass_scheduler.sv
// Bench for lowpass_scheduler: two instances (ATTENUATION 0 and 2) share stimulus and are
// checked against a per-channel arithmetic filter model plus directed timing checks.
module tb_lowpass_scheduler;
  localparam int CH = 4;
  localparam int BI = 12;
  localparam int BO = 16;
  localparam int DW = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [DW-1:0]    div = '0;
  logic             clear = 1'b0;
  logic [CH*BI-1:0] in_data = '0;
  logic [CH-1:0]    in_valid = '0;

  logic             out_valid_w [2];
  logic [1:0]       out_chan_w  [2];
  logic [BO-1:0]    out_data_w  [2];
  logic             busy_w      [2];
  logic             overrun_w   [2];
  logic             dbg_w       [2];
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
  logic [7:0]       ovc_w       [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int period_exp = 0;

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  lowpass_scheduler #(.CHANNELS(CH), .BITS_IN(BI), .BITS_OUT(BO), .ATTENUATION(0), .DIV_BITS(DW)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .div(div), .clear(clear),
    .in_data(in_data), .in_valid(in_valid),
    .out_valid(out_valid_w[0]), .out_chan(out_chan_w[0]), .out_data(out_data_w[0]),
    .busy(busy_w[0]), .overrun(overrun_w[0]),
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
    .overrun_cnt(ovc_w[0]),
`endif
    .dbg_state(dbg_w[0])
  );

  lowpass_scheduler #(.CHANNELS(CH), .BITS_IN(BI), .BITS_OUT(BO), .ATTENUATION(2), .DIV_BITS(DW)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .div(div), .clear(clear),
    .in_data(in_data), .in_valid(in_valid),
    .out_valid(out_valid_w[1]), .out_chan(out_chan_w[1]), .out_data(out_data_w[1]),
    .busy(busy_w[1]), .overrun(overrun_w[1]),
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
    .overrun_cnt(ovc_w[1]),
`endif
    .dbg_state(dbg_w[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_sample(input int k, input int val);
    in_data[k*BI +: BI] = BI'(val);
    in_valid[k] = 1'b1;
  endtask

  task automatic wait_out(input int inst, input int c, output int val);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    val = 0;
    while (!found && n < 300) begin
      @(posedge clock);
      #1;
      n++;
      if (out_valid_w[inst] && int'(out_chan_w[inst]) == c) begin
        val = int'($signed(out_data_w[inst]));
        found = 1'b1;
      end
    end
    if (!found) check("wait_timeout", 0, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_valid"}, int'(out_valid_w[i]), 0);
      check({tag, "_chan"}, int'(out_chan_w[i]), 0);
      check({tag, "_data"}, int'(out_data_w[i]), 0);
      check({tag, "_busy"}, int'(busy_w[i]), 0);
      check({tag, "_ovr"}, int'(overrun_w[i]), 0);
      check({tag, "_dbg"}, int'(dbg_w[i]), 0);
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
      check({tag, "_ovc"}, int'(ovc_w[i]), 0);
`endif
    end
  endtask

  // scoreboard: per-instance filter model, expected channel order queue
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int ATT = (gi == 0) ? 0 : 2;
    logic [1:0] exp_q [$];
    shortint    m_sum  [CH];
    int         m_hold [CH];
    int         last_t = -1;

    always @(posedge clock) begin : mon
      int c;
      int tmp;
      shortint e;
      logic signed [BI-1:0] sl;
      #1;
      if (!reset_n) begin
        for (int k = 0; k < CH; k++) begin
          m_sum[k]  = 0;
          m_hold[k] = 0;
        end
        exp_q.delete();
        last_t = -1;
      end else begin
        if (out_valid_w[gi]) begin
          if (exp_q.size() == 0) begin
            for (int k = 0; k < CH; k++) exp_q.push_back(2'(k));
          end
          c = int'(exp_q.pop_front());
          check("out_chan", int'(out_chan_w[gi]), c);
          tmp = int'(m_sum[c]) + (m_hold[c] >>> ATT) - (int'(m_sum[c]) >>> (BO - BI));
          e = shortint'(tmp);
          check("out_data", int'($signed(out_data_w[gi])), int'(e));
          m_sum[c] = e;
          if (c == 0) begin
            if (period_exp != 0 && last_t >= 0) check("scan_period", cyc - last_t, period_exp);
            last_t = cyc;
          end
        end else if (exp_q.size() != 0 && !clear) begin
          check("scan_gap", 0, 1);
          exp_q.delete();
        end
        if (clear) begin
          check("clear_valid", int'(out_valid_w[gi]), 0);
          for (int k = 0; k < CH; k++) m_sum[k] = 0;
          exp_q.delete();
        end
        for (int k = 0; k < CH; k++) begin
          if (in_valid[k]) begin
            sl = in_data[k*BI +: BI];
            m_hold[k] = int'(sl);
          end
        end
      end
    end
  end

  initial begin
    int v;
    int n;
    int a;
    bit found;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    div = DW'(8);
    period_exp = 8;

    // step response: ch0 = +100, ch2 = +400, others 0
    drive_sample(0, 100);
    drive_sample(1, 0);
    drive_sample(2, 400);
    drive_sample(3, 0);
    @(negedge clock);
    in_valid = '0;
    wait_out(0, 0, v); check("ch0_first", v, 100);
    wait_out(1, 2, v); check("att_first", v, 100);
    wait_out(0, 0, v); check("ch0_second", v, 194);
    wait_out(0, 0, v); check("ch0_third", v, 282);
    repeat (1300) @(posedge clock);
    wait_out(0, 0, v); check("ch0_steady", int'(v >= 1600 && v <= 1615), 1);
    wait_out(1, 2, v); check("att_steady", int'(v >= 1600 && v <= 1615), 1);
    wait_out(0, 1, v); check("ch1_idle", v, 0);
    wait_out(0, 3, v); check("ch3_idle", v, 0);
    check("ovr_none0", int'(overrun_w[0]), 0);
    check("ovr_none1", int'(overrun_w[1]), 0);
    period_exp = 0;

    // negative input with floor shift
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    drive_sample(1, -100);
    @(negedge clock); in_valid = '0;
    wait_out(0, 1, v); check("neg_first", v, -100);
    wait_out(0, 1, v); check("neg_second", v, -193);

    // ticks faster than a scan
    @(negedge clock); div = DW'(3);
    repeat (40) @(posedge clock);
    #1;
    check("ovr_set0", int'(overrun_w[0]), 1);
    check("ovr_set1", int'(overrun_w[1]), 1);
`ifdef LOWPASS_SCHEDULER_OVERRUN_CNT_EN
    a = int'(ovc_w[0]);
    repeat (60) @(posedge clock);
    #1;
    check("ovc_rate", int'(ovc_w[0]) - a, 10);
    repeat (1600) @(posedge clock);
    #1;
    check("ovc_sat0", int'(ovc_w[0]), 255);
    check("ovc_sat1", int'(ovc_w[1]), 255);
    check("ovr_sat", int'(overrun_w[0]), 1);
`else
    repeat (100) @(posedge clock);
    #1;
    check("ovr_sticky", int'(overrun_w[0]), 1);
`endif

    // clear in the middle of a scan
    @(negedge clock); div = DW'(8);
    repeat (30) @(posedge clock);
    wait_out(0, 1, v);
    @(negedge clock); clear = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("abort_valid", int'(out_valid_w[i]), 0);
      check("abort_busy", int'(busy_w[i]), 0);
      check("abort_ovr", int'(overrun_w[i]), 0);
    end
    @(negedge clock); clear = 1'b0;
    wait_out(0, 0, v); check("post_clr_ch0", v, 100);
    wait_out(0, 1, v); check("post_clr_ch1", v, -100);
    wait_out(0, 2, v); check("post_clr_ch2", v, 400);
    check("post_clr_att", int'($signed(out_data_w[1])), 100);

    // halted divider, restart latency, async reset mid-scan
    @(negedge clock); div = '0;
    repeat (30) @(posedge clock);
    n = 0;
    repeat (100) begin
      @(posedge clock);
      #1;
      if (out_valid_w[0] || out_valid_w[1]) n++;
    end
    check("halt_quiet", n, 0);
    @(negedge clock); div = DW'(5);
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(posedge clock);
      #1;
      n++;
      if (out_valid_w[0]) found = 1'b1;
    end
    check("restart_latency", n, 6);
    check("restart_chan", int'(out_chan_w[0]), 0);
    @(posedge clock);
    #1;
    check("mid_scan_chan", int'(out_chan_w[0]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
      check("rst_release_valid0", int'(out_valid_w[0]), 0);
      check("rst_release_valid1", int'(out_valid_w[1]), 0);
    end

    // randomized traffic
    for (int r = 0; r < 800; r++) begin
      @(negedge clock);
      if (r % 200 == 0) div = DW'($urandom_range(5, 12));
      in_valid = CH'($urandom_range(0, 15));
      for (int k = 0; k < CH; k++) in_data[k*BI +: BI] = BI'($urandom_range(0, 4095));
      clear = ($urandom_range(0, 49) == 0);
    end
    @(negedge clock);
    clear = 1'b0;
    in_valid = '0;
    div = '0;
    repeat (40) @(posedge clock);
    #1;
    check("q_empty0", g_mon[0].exp_q.size(), 0);
    check("q_empty1", g_mon[1].exp_q.size(), 0);
    check("rand_ovr0", int'(overrun_w[0]), 0);
    check("rand_ovr1", int'(overrun_w[1]), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
